// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the data-RAM port arbiter.
//   port_id_t : index of a requester port (0 = core LSU, 1 = loader/debug)
//   mem_req_t : one requester's access (byte address, store data, byte mask)
//   RD_MASK   : byte mask value that encodes a read
//   FULL_MASK : all four byte lanes enabled
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int DATA_W = 32;

    localparam logic [3:0] RD_MASK   = 4'b0000;
    localparam logic [3:0] FULL_MASK = 4'b1111;

    typedef logic [0:0] port_id_t;

    typedef struct packed {
        logic [31:0]       addr;
        logic [DATA_W-1:0] wdata;
        logic [3:0]        wmask;
    } mem_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter. The grant is purely combinational from the
// request vector and the remembered last winner; the last winner is updated
// whenever a grant is issued (a grant always means an accepted request,
// since grant is never raised without the matching valid).
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset (last winner -> port 1, so
//               port 0 wins the first contention)
//   valid[1:0]: request vector
//   grant[1:0]: one-hot (or zero) grant
//   grant_id  : index of the granted port (meaningful when grant != 0)
// -----------------------------------------------------------------------------
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    output logic [1:0] grant,
    output port_id_t   grant_id
);

    port_id_t last_grant;

    always_comb begin
        grant    = 2'b00;
        grant_id = 1'b0;
        case (valid)
            2'b01: begin
                grant    = 2'b01;
                grant_id = 1'b0;
            end
            2'b10: begin
                grant    = 2'b10;
                grant_id = 1'b1;
            end
            2'b11: begin
                // Contention: the port that did not win last time goes first.
                if (last_grant == 1'b1) begin
                    grant    = 2'b01;
                    grant_id = 1'b0;
                end else begin
                    grant    = 2'b10;
                    grant_id = 1'b1;
                end
            end
            default: begin
                grant    = 2'b00;
                grant_id = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (grant != 2'b00) begin
            last_grant <= grant_id;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single-port data RAM between the core load/store unit (port 0)
// and the program loader / debug master (port 1). Requests use a valid/ready
// handshake; at most one RAM access is issued per cycle with round-robin
// arbitration. The RAM has one cycle of read latency, so the response for a
// request accepted in cycle T is presented in T+1 on the accepting port.
// Out-of-range requests (byte address >= MEM_WORDS*4) never touch the RAM and
// are answered with rsp_err=1 and zero data.
//
// Ports:
//   clk, reset          : clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready : per-port handshake, bit i = port i
//   req_addr/wdata/wmask: per-port request; wmask 0 = read, else byte write
//   rsp_valid           : per-port one-cycle response strobe
//   rsp_rdata, rsp_err  : response data / out-of-range flag
//   mem_en/addr/wdata/wmask : RAM request, driven combinationally
//   mem_rdata           : RAM read data, valid the cycle after mem_en
//
// Build option MEM_PORT_ARBITER_PERF_EN adds saturating 32-bit counters
// perf_grants0, perf_grants1 (accepted requests per port) and perf_stalls
// (cycles where some valid request is not granted).
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int ADDR_W    = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   req_valid,
    output logic [1:0]                   req_ready,
    input  logic [1:0][ADDR_W-1:0]       req_addr,
    input  logic [1:0][DATA_W-1:0]       req_wdata,
    input  logic [1:0][3:0]              req_wmask,
    output logic [1:0]                   rsp_valid,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         rsp_err,
    output logic                         mem_en,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    output logic [3:0]                   mem_wmask,
    input  logic [DATA_W-1:0]            mem_rdata
`ifdef MEM_PORT_ARBITER_PERF_EN
    ,
    output logic [31:0]                  perf_grants0,
    output logic [31:0]                  perf_grants1,
    output logic [31:0]                  perf_stalls
`endif
);

    localparam int MA_W = $clog2(MEM_WORDS);

    logic [1:0]        grant;
    port_id_t          gnt_id;
    logic [ADDR_W-1:0] addr_p0;
    mem_req_t          req_p0;
    logic              acc_p0;
    logic              in_range_p0;
    logic              rd_p0;
    logic              unused_addr_bits;

    logic [1:0]        vld_p1;
    logic              rd_p1;
    logic              err_p1;

    rr_arbiter2 u_rr (
        .clk      (clk),
        .rst_n    (reset),
        .valid    (req_valid),
        .grant    (grant),
        .grant_id (gnt_id)
    );

    // ---- stage p0: grant, range check and RAM request (combinational) ----
    always_comb begin
        addr_p0      = req_addr[gnt_id];
        req_p0.addr  = 32'(addr_p0);
        req_p0.wdata = req_wdata[gnt_id];
        req_p0.wmask = req_wmask[gnt_id];

        acc_p0       = (grant != 2'b00);
        in_range_p0  = (addr_p0 >> 2) < ADDR_W'(MEM_WORDS);
        rd_p0        = (req_p0.wmask == RD_MASK);

        req_ready    = grant;
        mem_en       = acc_p0 & in_range_p0;
        mem_addr     = req_p0.addr[MA_W+1:2];
        mem_wdata    = req_p0.wdata;
        mem_wmask    = mem_en ? (req_p0.wmask & FULL_MASK) : RD_MASK;
    end

    // Byte offset and the bits above the RAM word index are not part of the
    // RAM address; the range check above already covers the upper bits.
    assign unused_addr_bits = ^{req_p0.addr[1:0], req_p0.addr[31:MA_W+2]};

    // ---- stage p1: response for the request accepted in the previous cycle ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1 <= 2'b00;
        end else begin
            vld_p1 <= grant;
        end
    end

    always_ff @(posedge clk) begin
        if (acc_p0) begin
            rd_p1  <= rd_p0;
            err_p1 <= ~in_range_p0;
        end
    end

    always_comb begin
        rsp_valid = vld_p1;
        rsp_err   = (vld_p1 != 2'b00) & err_p1;
        // Writes are acknowledged with zero data; errored reads never hit RAM.
        rsp_rdata = ((vld_p1 != 2'b00) & rd_p1 & ~err_p1) ? mem_rdata : '0;
    end

`ifdef MEM_PORT_ARBITER_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_grants0 <= '0;
            perf_grants1 <= '0;
            perf_stalls  <= '0;
        end else begin
            if (grant[0]) perf_grants0 <= sat_inc(perf_grants0);
            if (grant[1]) perf_grants1 <= sat_inc(perf_grants1);
            if ((req_valid & ~grant) != 2'b00) perf_stalls <= sat_inc(perf_stalls);
        end
    end
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port data RAM between two requesters: port 0 is the core load/store unit, port 1 is the program loader/debug master.
- Uses valid/ready request handshake, one-cycle memory read latency and round-robin grant.
- Sits between the core's memRdata/memWdata/addr/memWMask datapath and the RAM macro.
- Issues at most one RAM access per cycle; back-to-back accesses at full rate.

Parameters:
- MEM_WORDS, 1024, RAM depth in 32-bit words; byte addresses ≥ MEM_WORDS*4 are out of range.
- ADDR_W, 32, requester byte-address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester request valid (bit i = port i).
- req_ready  out  2  per-requester grant; request accepted when valid&ready.
- req_addr  in  2x ADDR_W  byte address per port; bits [1:0] ignored.
- req_wdata  in  2x32  store data per port.
- req_wmask  in  2x4  byte write mask; 0 = read.
- rsp_valid  out  2  response strobe, one cycle.
- rsp_rdata  out  32  read data, valid with rsp_valid.
- rsp_err  out  1  out-of-range flag, valid with rsp_valid.
- mem_en  out  1  RAM access enable.
- mem_addr  out  log2(MEM_WORDS)  word address (req_addr[.. :2]).
- mem_wdata  out  32  RAM write data.
- mem_wmask  out  4  RAM byte write enables.
- mem_rdata  in  32  RAM read data, valid cycle after mem_en.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_en=0, mem_wmask=0, last_grant=1 (port 0 wins first contention).
- Grant is combinational from req_valid and last_grant. At most one req_ready bit is high. No ready without valid.
- Arbitration:
  - Only one port valid → grant it.
  - Both valid → grant the port ≠ last_grant.
  - last_grant updates on every accepted request.
- Accept cycle T:
  - mem_en=1 and mem_addr/wdata/wmask are driven combinationally from the granted port in T.
  - Out of range: mem_en=0, mem_wmask=0.
- Response at T+1 on the accepting port:
  - rsp_valid[i]=1.
  - Read: rsp_rdata=mem_rdata.
  - Write: rsp_rdata=0 (ack only).
  - rsp_err=1 if out of range, rsp_rdata=0.
- Pipeline regs hold grant id, is_read, err. A new request may be accepted in T+1 while its predecessor's response is driven.
- Fairness: under continuous contention, grants alternate 0,1,0,1…; no port waits more than one accepted request.
- Requester must hold addr/wdata/wmask stable while valid & !ready. The arbiter does not latch them.
- Reset mid-operation: the pending response is discarded, no rsp_valid after reset deasserts; last_grant returns to 1.
- Sub-word mask on read (wmask=0) only; any nonzero mask is a write with exactly those bytes enabled.

Optional Feature:
- Macro MEM_PORT_ARBITER_PERF_EN.
- Defined:
  - Adds outputs perf_grants0, perf_grants1, perf_stalls (32-bit each), reset to 0.
  - grants count accepted requests per port.
  - stalls count cycles where some req_valid bit is high without ready.
  - All counters saturate at 0xFFFFFFFF.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package mem_arb_pkg:
  - typedef port_id_t (1 bit).
  - struct mem_req_t {addr, wdata, wmask}.
  - localparams RD_MASK=4'b0000, FULL_MASK=4'b1111.
- Sub-module rr_arbiter2: combinational 2-way round-robin grant from valid + last_grant, plus last_grant register. Reused later for the instruction/data merge.

Test Plan:
- Port 0 write addr 0x10, wdata 0xDEADBEEF, wmask 0xF; then read 0x10 → mem_en in accept cycle; rsp_valid[0] next cycle with rdata 0xDEADBEEF, rsp_err=0.
- Both ports valid continuously for 6 cycles, reads at 0x0 and 0x4 → ready pattern 01,10,01,10,01,10; responses alternate accordingly.
- Byte write wmask=0x2, wdata 0x0000AB00 over 0x11223344 at 0x20 → readback 0x1122AB44.
- Port 1 read at MEM_WORDS*4 (0x1000) → mem_en=0; rsp_valid[1]=1, rsp_err=1, rdata=0.
- Assert reset (low) in the cycle after a port-0 read is accepted → rsp_valid stays 0 through and after reset; first contended grant after release goes to port 0.
- With MEM_PORT_ARBITER_PERF_EN: 3 port-0 grants, 2 port-1 grants, 2 stall cycles → perf_grants0=3, perf_grants1=2, perf_stalls=2.
